// File: rtl/traffic_conflict_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : traffic_conflict_monitor                                      |
// | Purpose  : Safety stage between the traffic-light controller and the     |
// |            lamps. Passes lamp requests through with one clock of         |
// |            latency and forces a latched flashing-red failsafe on         |
// |            illegal or conflicting indications.                           |
// | Options  : MON_YLW_CHECK_EN - adds the minimum-yellow-duration check     |
// |            (fault code 100).                                             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module traffic_conflict_monitor #(
  parameter int FAULT_TICKS   = 2,
  parameter int FLASH_DIV     = 4,
  parameter int RECOVER_TICKS = 8,
  parameter int MIN_YLW       = 3
) (
  input  logic       clock,
  input  logic       pclr,
  input  logic       pclk,
  input  logic       pgrn1,
  input  logic       pylw1,
  input  logic       pred1,
  input  logic       pgrn2,
  input  logic       pylw2,
  input  logic       pred2,
  input  logic       pack,
  output logic       lgrn1,
  output logic       lylw1,
  output logic       lred1,
  output logic       lgrn2,
  output logic       lylw2,
  output logic       lred2,
  output logic       pfault,
  output logic [2:0] fault_code
);

  localparam logic [3:0] c_fault_ticks   = 4'(FAULT_TICKS);
  localparam logic [3:0] c_flash_div     = 4'(FLASH_DIV);
  localparam logic [7:0] c_recover_ticks = 8'(RECOVER_TICKS);

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_FLASH   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t     r_state;
  logic [3:0] r_dbc;     // consecutive violating ticks
  logic [3:0] r_fdiv;    // ticks since last flash phase change
  logic       r_phase;   // flash phase driven onto both reds
  logic [7:0] r_rcnt;    // ticks spent in steady all-red recovery

  logic [2:0] w_app1, w_app2;
  logic       w_legal1, w_legal2, w_conflict, w_any_viol, w_short;
  logic       w_latch, w_recover_done;
  logic [3:0] w_dbc_inc;
  logic [2:0] w_code;

  assign w_app1   = {pgrn1, pylw1, pred1};
  assign w_app2   = {pgrn2, pylw2, pred2};
  assign w_legal1 = (w_app1 == 3'b100) | (w_app1 == 3'b010) | (w_app1 == 3'b001);
  assign w_legal2 = (w_app2 == 3'b100) | (w_app2 == 3'b010) | (w_app2 == 3'b001);
  // Conflict means both approaches are showing a proceed/caution aspect.
  assign w_conflict = (pgrn1 | pylw1) & (pgrn2 | pylw2);
  assign w_any_viol = w_conflict | ~w_legal1 | ~w_legal2;

  assign w_dbc_inc      = (r_dbc == 4'hF) ? r_dbc : r_dbc + 4'd1;
  assign w_latch        = (r_state == ST_NORMAL) & pclk &
                          (w_short | (w_any_viol & (w_dbc_inc >= c_fault_ticks)));
  assign w_recover_done = (r_state == ST_RECOVER) & pclk &
                          (r_rcnt >= c_recover_ticks - 8'd1);

`ifdef MON_YLW_CHECK_EN
  localparam logic [3:0] c_min_ylw = 4'(MIN_YLW);

  logic [3:0] r_ycnt1, r_ycnt2;
  logic       w_ylw1, w_ylw2, w_red1, w_red2;

  assign w_ylw1 = (w_app1 == 3'b010);
  assign w_ylw2 = (w_app2 == 3'b010);
  assign w_red1 = (w_app1 == 3'b001);
  assign w_red2 = (w_app2 == 3'b001);
  // A non-zero count means the previous tick was yellow-alone.
  assign w_short = ((r_ycnt1 != 4'd0) & w_red1 & (r_ycnt1 < c_min_ylw)) |
                   ((r_ycnt2 != 4'd0) & w_red2 & (r_ycnt2 < c_min_ylw));

  // Per-approach yellow duration, saturating at MIN_YLW, zeroed when yellow drops.
  always_ff @(posedge clock) begin
    if (pclr || w_recover_done) begin
      r_ycnt1 <= 4'd0;
      r_ycnt2 <= 4'd0;
    end else if (r_state == ST_NORMAL && pclk) begin
      r_ycnt1 <= w_ylw1 ? ((r_ycnt1 < c_min_ylw) ? r_ycnt1 + 4'd1 : r_ycnt1) : 4'd0;
      r_ycnt2 <= w_ylw2 ? ((r_ycnt2 < c_min_ylw) ? r_ycnt2 + 4'd1 : r_ycnt2) : 4'd0;
    end
  end
`else
  localparam logic [3:0] c_min_ylw_unused = 4'(MIN_YLW);
  assign w_short = 1'b0;
`endif

  // Fault cause from the current tick, highest priority first.
  always_comb begin
    w_code = 3'b000;
    if (w_conflict)     w_code = 3'b001;
    else if (!w_legal1) w_code = 3'b010;
    else if (!w_legal2) w_code = 3'b011;
    else if (w_short)   w_code = 3'b100;
  end

  // Supervisory state machine with registered lamp and fault outputs.
  always_ff @(posedge clock) begin
    if (pclr) begin
      r_state    <= ST_NORMAL;
      r_dbc      <= 4'd0;
      r_fdiv     <= 4'd0;
      r_phase    <= 1'b0;
      r_rcnt     <= 8'd0;
      pfault     <= 1'b0;
      fault_code <= 3'b000;
      {lgrn1, lylw1, lred1, lgrn2, lylw2, lred2} <= 6'b001_001;
    end else begin
      case (r_state)
        ST_NORMAL: begin
          if (pclk) r_dbc <= w_any_viol ? w_dbc_inc : 4'd0;
          if (w_latch) begin
            // The violating request is never shown on the latching edge.
            r_state    <= ST_FLASH;
            pfault     <= 1'b1;
            fault_code <= w_code;
            r_phase    <= 1'b1;
            r_fdiv     <= 4'd0;
            {lgrn1, lylw1, lred1, lgrn2, lylw2, lred2} <= 6'b001_001;
          end else begin
            {lgrn1, lylw1, lred1, lgrn2, lylw2, lred2} <= {w_app1, w_app2};
          end
        end
        ST_FLASH: begin
          {lgrn1, lylw1, lgrn2, lylw2} <= 4'b0000;
          if (pack) begin
            // Acknowledge wins over a coincident tick; that tick is not counted.
            r_state <= ST_RECOVER;
            r_rcnt  <= 8'd0;
            lred1   <= 1'b1;
            lred2   <= 1'b1;
          end else if (pclk && (r_fdiv >= c_flash_div - 4'd1)) begin
            r_fdiv  <= 4'd0;
            r_phase <= ~r_phase;
            lred1   <= ~r_phase;
            lred2   <= ~r_phase;
          end else begin
            if (pclk) r_fdiv <= r_fdiv + 4'd1;
            lred1 <= r_phase;
            lred2 <= r_phase;
          end
        end
        ST_RECOVER: begin
          {lgrn1, lylw1, lred1, lgrn2, lylw2, lred2} <= 6'b001_001;
          if (w_recover_done) begin
            r_state    <= ST_NORMAL;
            pfault     <= 1'b0;
            fault_code <= 3'b000;
            r_dbc      <= 4'd0;
            r_rcnt     <= 8'd0;
          end else if (pclk) begin
            r_rcnt <= r_rcnt + 8'd1;
          end
        end
        default: r_state <= ST_NORMAL;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_traffic_conflict_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_traffic_conflict_monitor                                   |
// | Purpose  : Self-checking bench for traffic_conflict_monitor: directed    |
// |            scenarios plus randomized traffic against a behavioural      |
// |            model. Honours MON_YLW_CHECK_EN.                              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_traffic_conflict_monitor;

  localparam int P_FAULT = 2;
  localparam int P_DIV   = 4;
  localparam int P_REC   = 8;
  localparam int P_MINY  = 3;

  logic clock = 1'b0;
  logic pclr, pclk, pack;
  logic pgrn1, pylw1, pred1, pgrn2, pylw2, pred2;
  logic lgrn1, lylw1, lred1, lgrn2, lylw2, lred2, pfault;
  logic [2:0] fault_code;
  logic [9:0] obs;     // {lamps g1 y1 r1 g2 y2 r2, pfault, fault_code}
  logic [9:0] exp_v;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: run lengths and tick counts since mode entry.
  int         m_mode;        // 0 normal, 1 flash, 2 recover
  int         m_viol_run;
  int         m_yrun1, m_yrun2;
  int         m_flash_ticks, m_rec_ticks;
  logic [5:0] m_lamps;
  logic       m_pfault;
  logic [2:0] m_code;

  assign obs = {lgrn1, lylw1, lred1, lgrn2, lylw2, lred2, pfault, fault_code};

  always #5 clock = ~clock;

  traffic_conflict_monitor #(
    .FAULT_TICKS(P_FAULT), .FLASH_DIV(P_DIV), .RECOVER_TICKS(P_REC), .MIN_YLW(P_MINY)
  ) dut (
    .clock(clock), .pclr(pclr), .pclk(pclk),
    .pgrn1(pgrn1), .pylw1(pylw1), .pred1(pred1),
    .pgrn2(pgrn2), .pylw2(pylw2), .pred2(pred2),
    .pack(pack),
    .lgrn1(lgrn1), .lylw1(lylw1), .lred1(lred1),
    .lgrn2(lgrn2), .lylw2(lylw2), .lred2(lred2),
    .pfault(pfault), .fault_code(fault_code)
  );

  task automatic model_update(input logic [5:0] req, input logic pk, input logic tk,
                              input logic rst);
    logic [2:0] a1, a2;
    bit conf, ill1, ill2, sy;
    a1 = req[5:3];
    a2 = req[2:0];
    if (rst) begin
      m_mode = 0; m_viol_run = 0; m_yrun1 = 0; m_yrun2 = 0;
      m_flash_ticks = 0; m_rec_ticks = 0;
      m_lamps = 6'b001001; m_pfault = 1'b0; m_code = 3'd0;
    end else if (m_mode == 0) begin
      m_lamps = req;
      if (tk) begin
        conf = (a1[2] | a1[1]) && (a2[2] | a2[1]);
        ill1 = ($countones(a1) != 1);
        ill2 = ($countones(a2) != 1);
        sy   = 1'b0;
`ifdef MON_YLW_CHECK_EN
        if (m_yrun1 > 0 && a1 == 3'b001 && m_yrun1 < P_MINY) sy = 1'b1;
        if (m_yrun2 > 0 && a2 == 3'b001 && m_yrun2 < P_MINY) sy = 1'b1;
`endif
        m_yrun1 = (a1 == 3'b010) ? m_yrun1 + 1 : 0;
        m_yrun2 = (a2 == 3'b010) ? m_yrun2 + 1 : 0;
        m_viol_run = (conf || ill1 || ill2) ? m_viol_run + 1 : 0;
        if (sy || m_viol_run >= P_FAULT) begin
          m_mode = 1; m_pfault = 1'b1; m_flash_ticks = 0; m_lamps = 6'b001001;
          m_code = conf ? 3'd1 : ill1 ? 3'd2 : ill2 ? 3'd3 : 3'd4;
        end
      end
    end else if (m_mode == 1) begin
      if (pk) begin
        m_mode = 2; m_rec_ticks = 0; m_lamps = 6'b001001;
      end else begin
        if (tk) m_flash_ticks++;
        m_lamps = (((m_flash_ticks / P_DIV) % 2) == 0) ? 6'b001001 : 6'b000000;
      end
    end else begin
      m_lamps = 6'b001001;
      if (tk) m_rec_ticks++;
      if (m_rec_ticks == P_REC) begin
        m_mode = 0; m_pfault = 1'b0; m_code = 3'd0;
        m_viol_run = 0; m_yrun1 = 0; m_yrun2 = 0;
      end
    end
  endtask

  // Drive one clock of stimulus, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic [5:0] req, input logic pk, input logic tk, input logic rst);
    {pgrn1, pylw1, pred1, pgrn2, pylw2, pred2} = req;
    pack = pk; pclk = tk; pclr = rst;
    @(posedge clock);
    model_update(req, pk, tk, rst);
    #1;
  endtask

  task automatic test_reset();
    step(6'b100100, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (obs !== 10'b001001_0_000) begin
      n_fail++; $display("FAIL reset_state: got %b expected %b", obs, 10'b001001_0_000);
    end
  endtask

  task automatic test_passthrough();
    logic [5:0] seq [3] = '{6'b100001, 6'b010001, 6'b001100};
    foreach (seq[i]) begin
      step(seq[i], 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (obs !== {seq[i], 4'b0_000}) begin
        n_fail++; $display("FAIL passthrough_%0d: got %b expected %b", i, obs, {seq[i], 4'b0_000});
      end
    end
    step(6'b001010, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== 10'b001010_0_000) begin
      n_fail++; $display("FAIL passthrough_notick: got %b expected %b", obs, 10'b001010_0_000);
    end
  endtask

  task automatic test_conflict();
    step(6'b100001, 1'b0, 1'b1, 1'b1);
    step(6'b100100, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs !== 10'b100100_0_000) begin
      n_fail++; $display("FAIL conflict_first_tick: got %b expected %b", obs, 10'b100100_0_000);
    end
    step(6'b100100, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs !== 10'b001001_1_001) begin
      n_fail++; $display("FAIL conflict_latch: got %b expected %b", obs, 10'b001001_1_001);
    end
    for (int i = 1; i <= 2 * P_DIV; i++) begin
      step(6'($urandom), 1'b0, 1'b1, 1'b0);
      exp_v = (((i / P_DIV) % 2) == 0) ? 10'b001001_1_001 : 10'b000000_1_001;
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL flash_tick_%0d: got %b expected %b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_recovery();
    step(6'b100100, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (obs !== 10'b001001_1_001) begin
      n_fail++; $display("FAIL recover_entry: got %b expected %b", obs, 10'b001001_1_001);
    end
    for (int i = 1; i <= P_REC; i++) begin
      step(6'b100100, 1'b1, 1'b0, 1'b0);
      step(6'b100100, 1'b1, 1'b1, 1'b0);
      exp_v = (i == P_REC) ? 10'b001001_0_000 : 10'b001001_1_001;
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL recover_tick_%0d: got %b expected %b", i, obs, exp_v);
      end
    end
    step(6'b100001, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== 10'b100001_0_000) begin
      n_fail++; $display("FAIL recover_passthrough: got %b expected %b", obs, 10'b100001_0_000);
    end
    step(6'b001100, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (obs !== 10'b001100_0_000) begin
      n_fail++; $display("FAIL pack_in_normal: got %b expected %b", obs, 10'b001100_0_000);
    end
  endtask

  task automatic test_debounce();
    step(6'b100001, 1'b0, 1'b1, 1'b1);
    step(6'b100000, 1'b0, 1'b1, 1'b0);
    step(6'b100001, 1'b0, 1'b1, 1'b0);
    step(6'b100000, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs !== 10'b100000_0_000) begin
      n_fail++; $display("FAIL debounce_cleared: got %b expected %b", obs, 10'b100000_0_000);
    end
    step(6'b100000, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== 10'b100000_0_000) begin
      n_fail++; $display("FAIL debounce_notick: got %b expected %b", obs, 10'b100000_0_000);
    end
    step(6'b100000, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs !== 10'b001001_1_011) begin
      n_fail++; $display("FAIL debounce_latch_code3: got %b expected %b", obs, 10'b001001_1_011);
    end
  endtask

  task automatic test_short_yellow();
    step(6'b100001, 1'b0, 1'b1, 1'b1);
    step(6'b100001, 1'b0, 1'b1, 1'b0);
    step(6'b010001, 1'b0, 1'b1, 1'b0);
    step(6'b010001, 1'b0, 1'b1, 1'b0);
    step(6'b001100, 1'b0, 1'b1, 1'b0);
`ifdef MON_YLW_CHECK_EN
    exp_v = 10'b001001_1_100;
`else
    exp_v = 10'b001100_0_000;
`endif
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL short_yellow_2ticks: got %b expected %b", obs, exp_v);
    end
    step(6'b100001, 1'b0, 1'b1, 1'b1);
    step(6'b100001, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < P_MINY; i++) step(6'b010001, 1'b0, 1'b1, 1'b0);
    step(6'b001100, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs !== 10'b001100_0_000) begin
      n_fail++; $display("FAIL full_yellow_3ticks: got %b expected %b", obs, 10'b001100_0_000);
    end
  endtask

  task automatic test_pclr_mid_flash();
    step(6'b100001, 1'b0, 1'b1, 1'b1);
    step(6'b010010, 1'b0, 1'b1, 1'b0);
    step(6'b010010, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < P_DIV; i++) step(6'b000000, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs !== 10'b000000_1_001) begin
      n_fail++; $display("FAIL flash_dark_phase: got %b expected %b", obs, 10'b000000_1_001);
    end
    step(6'b010010, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (obs !== 10'b001001_0_000) begin
      n_fail++; $display("FAIL pclr_mid_flash: got %b expected %b", obs, 10'b001001_0_000);
    end
    step(6'b100001, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs !== 10'b100001_0_000) begin
      n_fail++; $display("FAIL after_pclr_passthrough: got %b expected %b", obs, 10'b100001_0_000);
    end
  endtask

  task automatic test_random();
    logic [5:0] legal_pat [5] = '{6'b100001, 6'b010001, 6'b001001, 6'b001100, 6'b001010};
    logic [5:0] req;
    req = 6'b001001;
    step(req, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        if ($urandom_range(0, 9) < 8) req = legal_pat[$urandom_range(0, 4)];
        else                          req = 6'($urandom);
      end
      step(req, ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 499) == 0));
      n_checks++;
      if (obs !== {m_lamps, m_pfault, m_code}) begin
        n_fail++;
        $display("FAIL random_cycle_%0d: got %b expected %b", i, obs, {m_lamps, m_pfault, m_code});
      end
    end
  endtask

  initial begin
    {pgrn1, pylw1, pred1, pgrn2, pylw2, pred2} = 6'b001001;
    pack = 1'b0; pclk = 1'b0; pclr = 1'b1;
    test_reset();
    test_passthrough();
    test_conflict();
    test_recovery();
    test_debounce();
    test_short_yellow();
    test_pclr_mid_flash();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
